// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_LEN_LO,
    S_LEN_HI,
    S_WORD,
    S_WRITE,
    S_CSUM,
    S_RUN,
    S_ERROR
  } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs a little-endian byte stream into words: the first byte lands in bits [7:0].
module byte_assembler
  import loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [7:0]                data,
  output logic [8*WORD_BYTES-1:0]   word,
  output logic                      full
);

  logic [1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      word <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      word <= {data, word[8*WORD_BYTES-1:8]};
    end
  end

  // The counter wraps by itself, so no explicit clear is needed between words.
  assign full = en && (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: zero-fills instruction memory, then loads a length-prefixed,
// XOR-checksummed image from a byte stream and starts the CPU on success.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_CLEAR  | writing 0 to every imem address, one per cycle
// S_LEN_LO | waiting for length byte [7:0]
// S_LEN_HI | waiting for length byte [15:8], then range check
// S_WORD   | collecting the 4 bytes of the next word
// S_WRITE  | one-cycle imem write of the assembled word
// S_CSUM   | waiting for the checksum byte
// S_RUN    | image accepted, CPU started (terminal)
// S_ERROR  | bad length or checksum (terminal)
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              err_o
);

  loader_state_t state, state_nx;

  logic [ADDR_W-1:0] clr_cnt;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   ptr;
  logic [7:0]        csum;
  logic              accept;
  logic              asm_en;
  logic              asm_full;
  logic [31:0]       asm_word;

  assign accept   = rx_valid_i && rx_ready_o;
  assign len_full = {rx_data_i, len_lo};
  assign asm_en   = accept && (state == S_WORD);

  byte_assembler u_asm (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (asm_en),
    .data  (rx_data_i),
    .word  (asm_word),
    .full  (asm_full)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR:  if (clr_cnt == ADDR_W'(IMEM_DEPTH - 1)) state_nx = S_LEN_LO;
      S_LEN_LO: if (accept) state_nx = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_full > 16'(IMEM_DEPTH)) state_nx = S_ERROR;
          else if (len_full == 16'd0)     state_nx = S_CSUM;
          else                            state_nx = S_WORD;
        end
      end
      S_WORD:   if (asm_full) state_nx = S_WRITE;
      S_WRITE:  state_nx = (16'(ptr) + 16'd1 == len) ? S_CSUM : S_WORD;
      S_CSUM:   if (accept) state_nx = (rx_data_i == csum) ? S_RUN : S_ERROR;
      S_RUN:    state_nx = S_RUN;
      S_ERROR:  state_nx = S_ERROR;
      default:  state_nx = S_ERROR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clr_cnt <= '0;
      len_lo  <= '0;
      len     <= '0;
      ptr     <= '0;
      csum    <= '0;
    end else begin
      if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept && state == S_LEN_LO) len_lo <= rx_data_i;
      if (accept && state == S_LEN_HI) begin
        len <= len_full;
        ptr <= '0;
      end
      if (asm_en) csum <= csum ^ rx_data_i;
      if (state == S_WRITE) ptr <= ptr + 1'b1;
    end
  end

  // Every output is a decode of the state register (plus registered datapath).
  always_comb begin
    rx_ready_o   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                   (state == S_WORD)   || (state == S_CSUM);
    imem_we_o    = (state == S_CLEAR) || (state == S_WRITE);
    imem_addr_o  = (state == S_CLEAR) ? clr_cnt : ptr[ADDR_W-1:0];
    imem_wdata_o = (state == S_WRITE) ? asm_word : 32'd0;
    start_o      = (state == S_RUN);
    err_o        = (state == S_ERROR);
    busy_o       = !((state == S_RUN) || (state == S_ERROR));
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a behavioural instruction memory.
module tb_program_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        start_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [31:0] img [256];
  int          wr_cnt;

  program_loader #(.IMEM_DEPTH(256)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .start_o      (start_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory stand-in; scrambled while in reset so the clear is visible.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      wr_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hdeadbeef;
    end else if (imem_we_o) begin
      mem[imem_addr_o] <= imem_wdata_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk_i);
      rx_valid_i = 1'b0;
    end
    t = 0;
    @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_timeout: rx_ready_o=%b required 1", rx_ready_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  // Streams length, img[0..n-1] and checksum (xor'ed with bad_mask).
  task automatic send_image(input int n, input logic [7:0] bad_mask, input int maxgap);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [7:0]  b;
    cs = 8'h00;
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
    for (int wi = 0; wi < n; wi++) begin
      w = img[wi];
      for (int bi = 0; bi < 4; bi++) begin
        b = w[8*bi +: 8];
        cs ^= b;
        send_byte(b, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
      end
      checks++;
      if (imem_we_o !== 1'b1 || imem_addr_o !== wi[7:0] || imem_wdata_o !== w || rx_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL word_write[%0d]: we=%b addr=%0d data=%h ready=%b required we=1 addr=%0d data=%h ready=0",
                 wi, imem_we_o, imem_addr_o, imem_wdata_o, rx_ready_o, wi, w);
      end
    end
    send_byte(cs ^ bad_mask, 0);
  endtask

  task automatic apply_reset();
    int t;
    t = 0;
    @(negedge clk_i);
    #2;
    rst_i      = 1'b0;
    rx_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    while (!rx_ready_o && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (rx_ready_o !== 1'b1 || wr_cnt !== 256) begin
      errors++;
      $display("FAIL reset_clear: ready=%b writes=%0d required ready=1 writes=256", rx_ready_o, wr_cnt);
    end
  endtask

  task automatic test_reset();
    rst_i      = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(negedge clk_i);
    checks++;
    if (rx_ready_o !== 1'b0 || imem_we_o !== 1'b1 || imem_addr_o !== 8'd0 || imem_wdata_o !== 32'd0 ||
        start_o !== 1'b0 || busy_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b we=%b addr=%0d data=%h start=%b busy=%b err=%b required 0 1 0 0 0 1 0",
               rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, start_o, busy_o, err_o);
    end
  endtask

  task automatic test_clear();
    int bad;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_i);
      checks++;
      if (imem_we_o !== 1'b1 || imem_addr_o !== 8'(i) || imem_wdata_o !== 32'd0 || rx_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL clear_cycle[%0d]: we=%b addr=%0d data=%h ready=%b required we=1 addr=%0d data=0 ready=0",
                 i, imem_we_o, imem_addr_o, imem_wdata_o, rx_ready_o, i);
      end
    end
    @(negedge clk_i);
    checks++;
    if (rx_ready_o !== 1'b1 || start_o !== 1'b0 || busy_o !== 1'b1 || imem_we_o !== 1'b0 || wr_cnt !== 256) begin
      errors++;
      $display("FAIL clear_done: ready=%b start=%b busy=%b we=%b writes=%0d required 1 0 1 0 256",
               rx_ready_o, start_o, busy_o, imem_we_o, wr_cnt);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 32'd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_mem: %0d nonzero words, required 0", bad);
    end
  endtask

  task automatic test_good_image();
    img[0] = 32'h00500113;
    img[1] = 32'h00000013;
    // XOR of the eight payload bytes is 0x51.
    send_image(2, 8'h00, 0);
    checks++;
    if (start_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0 || rx_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL good_start: start=%b err=%b busy=%b ready=%b required 1 0 0 0", start_o, err_o, busy_o, rx_ready_o);
    end
    repeat (3) @(negedge clk_i);
    rx_valid_i = 1'b0;
    checks++;
    if (mem[0] !== 32'h00500113 || mem[1] !== 32'h00000013 || mem[2] !== 32'd0 || wr_cnt !== 258 || start_o !== 1'b1) begin
      errors++;
      $display("FAIL good_mem: m0=%h m1=%h m2=%h writes=%0d start=%b required 00500113 00000013 0 258 1",
               mem[0], mem[1], mem[2], wr_cnt, start_o);
    end
  endtask

  task automatic test_bad_csum();
    int bad;
    apply_reset();
    img[0] = 32'h00500113;
    img[1] = 32'h00000013;
    send_image(2, 8'h01, 0);
    checks++;
    if (err_o !== 1'b1 || start_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum: err=%b start=%b busy=%b required 1 0 0", err_o, start_o, busy_o);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      rx_valid_i = 1'b1;
      if (rx_ready_o !== 1'b0 || err_o !== 1'b1 || start_o !== 1'b0) bad++;
    end
    rx_valid_i = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bad_csum_hold: %0d cycles with ready/err/start off, required 0", bad);
    end
  endtask

  task automatic test_len_overflow();
    int bad;
    apply_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++;
    if (err_o !== 1'b1 || rx_ready_o !== 1'b0 || start_o !== 1'b0) begin
      errors++;
      $display("FAIL len_overflow: err=%b ready=%b start=%b required 1 0 0", err_o, rx_ready_o, start_o);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      rx_data_i = 8'h13;
      if (rx_ready_o !== 1'b0 || imem_we_o !== 1'b0) bad++;
    end
    rx_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bad != 0 || wr_cnt !== 256) begin
      errors++;
      $display("FAIL len_overflow_nowrite: bad=%0d writes=%0d required 0 256", bad, wr_cnt);
    end
  endtask

  task automatic test_len_zero();
    int bad;
    apply_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (rx_ready_o !== 1'b1 || imem_we_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL len_zero_csum_state: ready=%b we=%b err=%b required 1 0 0", rx_ready_o, imem_we_o, err_o);
    end
    send_byte(8'h00, 0);
    checks++;
    if (start_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL len_zero_start: start=%b err=%b required 1 0", start_o, err_o);
    end
    rx_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 32'd0) bad++;
    checks++;
    if (bad != 0 || wr_cnt !== 256) begin
      errors++;
      $display("FAIL len_zero_mem: nonzero=%0d writes=%0d required 0 256", bad, wr_cnt);
    end
  endtask

  task automatic test_reset_midload();
    int bad;
    apply_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h01, 0);
    send_byte(8'h50, 0);
    @(negedge clk_i);
    checks++;
    if (imem_we_o !== 1'b0 || wr_cnt !== 256) begin
      errors++;
      $display("FAIL midload_partial: we=%b writes=%0d required 0 256", imem_we_o, wr_cnt);
    end
    apply_reset();
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 32'd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midload_reclear: %0d nonzero words, required 0", bad);
    end
    img[0] = 32'hdeadbeef;
    img[1] = 32'h12345678;
    // Payload XOR is 0x2A; gaps exercise source stalls.
    send_image(2, 8'h00, 3);
    checks++;
    if (start_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL midload_start: start=%b err=%b required 1 0", start_o, err_o);
    end
    rx_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (mem[0] !== 32'hdeadbeef || mem[1] !== 32'h12345678 || mem[2] !== 32'd0 || wr_cnt !== 258) begin
      errors++;
      $display("FAIL midload_mem: m0=%h m1=%h m2=%h writes=%0d required deadbeef 12345678 0 258",
               mem[0], mem[1], mem[2], wr_cnt);
    end
  endtask

  task automatic test_full_depth();
    int bad;
    apply_reset();
    for (int i = 0; i < 256; i++)
      img[i] = {8'hA5 ^ 8'(i), 8'(i * 3), ~8'(i), 8'(i)};
    send_image(256, 8'h00, 0);
    checks++;
    if (start_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL full_depth_start: start=%b err=%b required 1 0", start_o, err_o);
    end
    rx_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) bad++;
    checks++;
    if (bad != 0 || wr_cnt !== 512) begin
      errors++;
      $display("FAIL full_depth_mem: wrong=%0d writes=%0d required 0 512", bad, wr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_good_image();
    test_bad_csum();
    test_len_overflow();
    test_len_zero();
    test_reset_midload();
    test_full_depth();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
